spike_expand_serializer: RTL and testbench
==========================================

Name: spike_expand_serializer

Overview:
- Parametrised, sequential successor to the flat 1-to-8 spike bit extenders.
- Accepts one N_CH-bit spike vector per handshake and registers it.
- Emits the vector as successive groups of LANES channels; each spike bit is replicated to an OUT_W-bit all-ones or all-zeros mask.
- Sits between the spike router and the synapse/weight-masking datapath; valid/ready on both sides.

Parameters:
- N_CH, 64: spike channels per input vector; must be a multiple of LANES.
- OUT_W, 8: width of each expanded mask.
- LANES, 8: channels emitted per output beat.
- GRP_W, derived = max(1, clog2(N_CH/LANES)): width of the group index.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector this cycle.
- in_spikes  in  N_CH  spike vector; bit k = channel k.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  LANES*OUT_W  lane i occupies bits [i*OUT_W +: OUT_W].
- out_group  out  GRP_W  index g of the current group.
- out_last  out  1  final beat of the current vector.
- vec_cnt  out  16  count of fully emitted vectors; wraps at 65535 -> 0.

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - state IDLE; in_ready=1;
  - out_valid=0, out_data=0, out_group=0, out_last=0, vec_cnt=0.
- Reset mid-vector discards the held vector; no further beats of it are emitted.
- G = N_CH/LANES beats per vector.
- Lane mapping: lane i of beat g = {OUT_W{spikes[g*LANES+i]}}.
  - Every bit of the mask is driven, including the MSB.
  - No partial-width fill.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - On in_valid: capture in_spikes into the vector register, g=0, go to SEND.
  - SEND: out_valid=1; out_group=g; out_last=(g==G-1).
    - On out_ready with !out_last: g<=g+1.
    - On out_ready with out_last:
      - vec_cnt<=vec_cnt+1;
      - if in_valid&&in_ready, capture the new vector, g<=0, stay in SEND;
      - otherwise go to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_last && out_ready).
  - This is a combinational path from out_ready; it is allowed.
- Latency: vector accepted at edge T -> beat 0 valid in the cycle after T.
- Throughput: one vector per G cycles with continuous out_ready.
- Output stability: while out_valid && !out_ready, out_data, out_group and out_last hold their values.
- Input ignored: in_valid while in_ready=0 is not captured and has no effect.
- G=1 case: every beat has out_last=1; out_group is constant 0.
- Outputs out_data, out_group and out_last are registered or decoded from registered state only; no combinational path from in_spikes.

Optional Feature:
- Macro: SPIKE_EXPAND_SKIP_ZERO_GROUP_EN.
- Defined:
  - Groups whose LANES spike bits are all zero are not emitted.
  - g advances to the next nonzero group; out_group reports the real index.
  - out_last marks the highest-indexed nonzero group.
  - An all-zero vector is accepted (in_ready=1 in IDLE), emits no beats, still increments vec_cnt, and leaves the block in IDLE.
  - Next-group search is priority logic over the registered vector; no extra latency cycle.
- Undefined: all G groups are always emitted, including zero groups.

Test Plan:
- Reset check: N_CH=64, LANES=8, OUT_W=8; hold rst 2 cycles mid-SEND -> out_valid=0, vec_cnt=0, in_ready=1 the cycle after release; discarded vector never appears.
- Mapping: in_spikes=64'h8000_0000_0000_0001, out_ready=1 -> 8 beats with group 0..7:
  - beat 0 out_data=64'h0000_0000_0000_00FF;
  - beat 7 out_data=64'hFF00_0000_0000_0000, out_last=1;
  - vec_cnt=1.
- Backpressure: toggle out_ready 1,0,0,1... -> each beat held unchanged while stalled; no beat lost or duplicated; in_ready=0 throughout SEND except the final beat's handshake cycle.
- Back-to-back: in_valid held high with vectors A then B, out_ready=1 -> B accepted in the same cycle A's beat 7 handshakes; B beat 0 follows with no bubble; 16 beats in 16 cycles.
- Wrap: preload via 65536 vectors (or force) -> vec_cnt goes 65535 -> 0.
- Skip (macro defined): in_spikes=64'h0000_0100_0000_0000 -> single beat, out_group=5, out_data lane 0 = 8'hFF, out_last=1; all-zero vector -> no beats, vec_cnt increments.

Source files
------------

// File: rtl/spike_expand_serializer.sv
// spike_expand_serializer
// Registers one N_CH-bit spike vector per input handshake and streams it out
// as N_CH/LANES beats of LANES channels. Each spike bit is widened into an
// OUT_W-bit all-ones or all-zeros mask for the weight-masking datapath.
// Optional feature macro: SPIKE_EXPAND_SKIP_ZERO_GROUP_EN -- when defined,
// groups whose spike bits are all zero are not emitted, and an all-zero
// vector is absorbed without producing any beats.
module spike_expand_serializer #(
   parameter int  N_CH  = 64,
   parameter int  OUT_W = 8,
   parameter int  LANES = 8,
   localparam int G     = N_CH / LANES,
   localparam int GRP_W = (G > 1) ? $clog2(G) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_CH-1:0]        in_spikes,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OUT_W-1:0] out_data,
   output logic [GRP_W-1:0]       out_group,
   output logic                   out_last,
   output logic [15:0]            vec_cnt
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [N_CH-1:0]  vec_q, vec_d;
   logic [GRP_W-1:0] grp_q, grp_d;
   logic [15:0]      vec_cnt_q, vec_cnt_d;

   logic [LANES-1:0] sel_bits;
   logic [GRP_W-1:0] next_grp;
   logic [GRP_W-1:0] first_grp;
   logic             in_any;
   logic             last_grp;
   logic             beat_done;
   logic             vec_done;
   logic             accept;

   // Pick the spike bits of the group currently being emitted.
   always_comb begin
      // NOTE: every signal written in a combinational block gets a default
      // first, so no path can leave it unassigned and infer a latch.
      sel_bits = '0;
      for (int g = 0; g < G; g++) begin
         if (grp_q == GRP_W'(g)) sel_bits = vec_q[g*LANES +: LANES];
      end
   end

`ifdef SPIKE_EXPAND_SKIP_ZERO_GROUP_EN
   logic [G-1:0] grp_nz;
   logic [G-1:0] in_nz;

   // Priority search for the next nonzero group of the held vector and the
   // first nonzero group of the incoming vector.
   always_comb begin
      grp_nz    = '0;
      in_nz     = '0;
      next_grp  = grp_q;
      first_grp = '0;
      last_grp  = 1'b1;
      in_any    = 1'b0;
      for (int g = 0; g < G; g++) begin
         grp_nz[g] = |vec_q[g*LANES +: LANES];
         in_nz[g]  = |in_spikes[g*LANES +: LANES];
      end
      // Descending scan: the lowest qualifying index is written last and wins.
      for (int g = G - 1; g >= 0; g--) begin
         if (grp_nz[g] && (g > int'(grp_q))) begin
            next_grp = GRP_W'(g);
            last_grp = 1'b0;
         end
         if (in_nz[g]) begin
            first_grp = GRP_W'(g);
            in_any    = 1'b1;
         end
      end
   end
`else
   // Every group is emitted in order; the last one is simply index G-1.
   always_comb begin
      next_grp  = grp_q + GRP_W'(1);
      first_grp = '0;
      in_any    = 1'b1;
      last_grp  = (grp_q == GRP_W'(G - 1));
   end
`endif

   assign out_valid = (state_q == ST_SEND);
   assign out_group = grp_q;
   assign out_last  = out_valid & last_grp;
   assign beat_done = out_valid & out_ready;
   assign vec_done  = beat_done & out_last;
   assign in_ready  = ~out_valid | vec_done;
   assign accept    = in_valid & in_ready;
   assign vec_cnt   = vec_cnt_q;

   // Widen each selected spike bit into a full lane mask; all zero when idle.
   always_comb begin
      out_data = '0;
      for (int i = 0; i < LANES; i++) begin
         out_data[i*OUT_W +: OUT_W] = {OUT_W{sel_bits[i] & out_valid}};
      end
   end

   // Next-state: advance group, retire vector, capture a new vector.
   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      grp_d     = grp_q;
      vec_cnt_d = vec_cnt_q;
      if (vec_done) begin
         state_d   = ST_IDLE;
         grp_d     = '0;
         vec_cnt_d = vec_cnt_q + 16'd1;
      end else if (beat_done) begin
         grp_d = next_grp;
      end
      if (accept) begin
         vec_d = in_spikes;
         if (in_any) begin
            state_d = ST_SEND;
            grp_d   = first_grp;
         end else begin
            // Nothing to emit: the vector counts as delivered immediately.
            vec_cnt_d = vec_cnt_d + 16'd1;
         end
      end
   end

   // Control registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples its pre-edge value regardless of block evaluation order.
      if (rst) begin
         state_q   <= ST_IDLE;
         grp_q     <= '0;
         vec_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         grp_q     <= grp_d;
         vec_cnt_q <= vec_cnt_d;
      end
   end

   // Held spike vector: pure data, loaded only on accept.
   always_ff @(posedge clk) begin
      // NOTE: the vector register is deliberately not reset; out_data is
      // gated by out_valid, so stale or unknown bits never reach the output.
      vec_q <= vec_d;
   end

endmodule

// File: tb/tb_spike_expand_serializer.sv
// Directed self-checking bench for spike_expand_serializer.
// Main instance: N_CH=64, LANES=8, OUT_W=8. Second instance: N_CH=8,
// LANES=8, OUT_W=2 (G=1), used for the single-group case and counter wrap.
module tb_spike_expand_serializer;

   localparam int N_CH  = 64;
   localparam int OUT_W = 8;
   localparam int LANES = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_spikes;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [2:0]  out_group;
   logic        out_last;
   logic [15:0] vec_cnt;

   logic        w_in_valid;
   logic        w_in_ready;
   logic [7:0]  w_in_spikes;
   logic        w_out_valid;
   logic        w_out_ready;
   logic [15:0] w_out_data;
   logic [0:0]  w_out_group;
   logic        w_out_last;
   logic [15:0] w_vec_cnt;

   int total = 0;
   int bad = 0;
   int exp_cnt = 0;

   spike_expand_serializer #(.N_CH(N_CH), .OUT_W(OUT_W), .LANES(LANES)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_spikes(in_spikes),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_group(out_group), .out_last(out_last), .vec_cnt(vec_cnt)
   );

   spike_expand_serializer #(.N_CH(8), .OUT_W(2), .LANES(8)) u_dut_g1 (
      .clk(clk), .rst(rst),
      .in_valid(w_in_valid), .in_ready(w_in_ready), .in_spikes(w_in_spikes),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
      .out_group(w_out_group), .out_last(w_out_last), .vec_cnt(w_vec_cnt)
   );

   always #5 clk = ~clk;

   // Reference lane mapping: lane i of beat g = {OUT_W{v[g*LANES+i]}}.
   function automatic logic [63:0] expand(input logic [63:0] v, input int g);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++) r[i*OUT_W +: OUT_W] = {OUT_W{v[g*LANES+i]}};
      return r;
   endfunction

   // Advance to just after the next rising edge (input drive slot).
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      total++;
      if ({out_valid, in_ready, vec_cnt, out_data, out_group, out_last} !== {1'b0, 1'b1, 16'd0, 64'd0, 3'd0, 1'b0}) begin
         bad++;
         $display("FAIL reset_state: valid=%b ready=%b cnt=%0d data=%h grp=%0d last=%b, want 0 1 0 0 0 0",
                  out_valid, in_ready, vec_cnt, out_data, out_group, out_last);
      end
      total++;
      if ({w_out_valid, w_in_ready, w_vec_cnt} !== {1'b0, 1'b1, 16'd0}) begin
         bad++;
         $display("FAIL reset_state_g1: valid=%b ready=%b cnt=%0d, want 0 1 0", w_out_valid, w_in_ready, w_vec_cnt);
      end
      // Start a vector, emit one beat, then reset in the middle of it.
      in_valid  = 1'b1;
      in_spikes = '1;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      #1;
      total++;
      if ({out_valid, in_ready} !== 2'b10) begin
         bad++;
         $display("FAIL reset_pre_send: valid=%b ready=%b, want 1 0", out_valid, in_ready);
      end
      out_ready = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      total++;
      if ({out_valid, in_ready, vec_cnt, out_data} !== {1'b0, 1'b1, 16'd0, 64'd0}) begin
         bad++;
         $display("FAIL reset_mid_send: valid=%b ready=%b cnt=%0d data=%h, want 0 1 0 0",
                  out_valid, in_ready, vec_cnt, out_data);
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_discard c=%0d: valid=%b, want 0", c, out_valid);
         end
      end
      out_ready = 1'b0;
   endtask

   // Accept one vector with out_ready held high and check every beat.
   task automatic send_vector(input logic [63:0] v, output logic [63:0] d0, output logic [63:0] d7);
      logic [69:0] act;
      logic [69:0] want;
      logic [2:0]  eg;
      d0 = '0;
      d7 = '0;
      in_valid  = 1'b1;
      in_spikes = v;
      out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL send_accept: in_ready=%b, want 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      for (int g = 0; g < 8; g++) begin
         #1;
         eg   = g[2:0];
         act  = {out_valid, out_group, out_last, in_ready, out_data};
         want = {1'b1, eg, (g == 7), (g == 7), expand(v, g)};
         total++;
         if (act !== want) begin
            bad++;
            $display("FAIL send_beat g=%0d: got %h, want %h", g, act, want);
         end
         if (g == 0) d0 = out_data;
         if (g == 7) d7 = out_data;
         tick();
      end
      exp_cnt++;
      #1;
      total++;
      if ({out_valid, vec_cnt} !== {1'b0, exp_cnt[15:0]}) begin
         bad++;
         $display("FAIL send_done: valid=%b cnt=%0d, want 0 %0d", out_valid, vec_cnt, exp_cnt);
      end
   endtask

   task automatic test_mapping();
      logic [63:0] d0;
      logic [63:0] d7;
      send_vector(64'h8000_0000_0000_0001, d0, d7);
      total++;
      if (d0 !== 64'h0000_0000_0000_00FF) begin
         bad++;
         $display("FAIL map_beat0: got %h, want 00000000000000ff", d0);
      end
      total++;
      if (d7 !== 64'hFF00_0000_0000_0000) begin
         bad++;
         $display("FAIL map_beat7: got %h, want ff00000000000000", d7);
      end
      total++;
      if (vec_cnt !== 16'd1) begin
         bad++;
         $display("FAIL map_cnt: got %0d, want 1", vec_cnt);
      end
   endtask

   task automatic test_zero_groups();
      logic [63:0] d0;
      logic [63:0] d7;
      // Zero groups are still emitted when skipping is disabled.
      send_vector(64'h0000_FF00_0000_0000, d0, d7);
   endtask

   task automatic test_backpressure();
      logic [63:0] v;
      logic [3:0]  pat;
      logic [69:0] act;
      logic [69:0] want;
      logic [2:0]  eg;
      int          g;
      int          c;
      v   = 64'h0123_4567_89AB_CDEF;
      pat = 4'b1001;
      in_valid  = 1'b1;
      in_spikes = v;
      out_ready = 1'b0;
      tick();
      g = 0;
      c = 0;
      while (g < 8 && c < 64) begin
         out_ready = pat[c % 4];
         // Offer a decoy vector whenever the block must not accept it.
         in_valid  = !(out_ready && g == 7);
         in_spikes = 64'hDEAD_BEEF_0000_FFFF;
         #1;
         eg   = g[2:0];
         act  = {out_valid, out_group, out_last, in_ready, out_data};
         want = {1'b1, eg, (g == 7), (out_ready && g == 7), expand(v, g)};
         total++;
         if (act !== want) begin
            bad++;
            $display("FAIL bp_beat c=%0d g=%0d: got %h, want %h", c, g, act, want);
         end
         if (out_ready) g++;
         c++;
         tick();
      end
      in_valid = 1'b0;
      total++;
      if (g != 8) begin
         bad++;
         $display("FAIL bp_timeout: beats=%0d, want 8", g);
      end
      exp_cnt++;
      #1;
      total++;
      if ({out_valid, vec_cnt} !== {1'b0, exp_cnt[15:0]}) begin
         bad++;
         $display("FAIL bp_done: valid=%b cnt=%0d, want 0 %0d", out_valid, vec_cnt, exp_cnt);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [63:0] a;
      logic [63:0] b;
      logic [69:0] act;
      logic [69:0] want;
      logic [2:0]  eg;
      a = 64'hAA55_0F0F_F0F0_1234;
      b = 64'h1122_3344_5566_7788;
      in_valid  = 1'b1;
      in_spikes = a;
      out_ready = 1'b1;
      tick();
      in_spikes = b;
      for (int c = 0; c < 16; c++) begin
         if (c >= 8) in_valid = 1'b0;
         #1;
         eg   = c[2:0];
         act  = {out_valid, out_group, out_last, in_ready, out_data};
         want = {1'b1, eg, (eg == 3'd7), (eg == 3'd7), expand((c < 8) ? a : b, c % 8)};
         total++;
         if (act !== want) begin
            bad++;
            $display("FAIL b2b_beat c=%0d: got %h, want %h", c, act, want);
         end
         tick();
      end
      exp_cnt += 2;
      #1;
      total++;
      if ({out_valid, vec_cnt} !== {1'b0, exp_cnt[15:0]}) begin
         bad++;
         $display("FAIL b2b_done: valid=%b cnt=%0d, want 0 %0d", out_valid, vec_cnt, exp_cnt);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_skip();
      total++;
      // Single nonzero group 5, lane 0.
      in_valid  = 1'b1;
      in_spikes = 64'h0000_0100_0000_0000;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      #1;
      if ({out_valid, out_group, out_last, out_data} !== {1'b1, 3'd5, 1'b1, 64'h0000_0000_0000_00FF}) begin
         bad++;
         $display("FAIL skip_single: valid=%b grp=%0d last=%b data=%h, want 1 5 1 ff",
                  out_valid, out_group, out_last, out_data);
      end
      out_ready = 1'b1;
      tick();
      exp_cnt++;
      total++;
      if ({out_valid, vec_cnt} !== {1'b0, exp_cnt[15:0]}) begin
         bad++;
         $display("FAIL skip_single_done: valid=%b cnt=%0d, want 0 %0d", out_valid, vec_cnt, exp_cnt);
      end
      // Groups 0 and 7 only.
      in_valid  = 1'b1;
      in_spikes = 64'h8000_0000_0000_0001;
      tick();
      in_valid = 1'b0;
      #1;
      total++;
      if ({out_valid, out_group, out_last, out_data} !== {1'b1, 3'd0, 1'b0, 64'h0000_0000_0000_00FF}) begin
         bad++;
         $display("FAIL skip_two_first: valid=%b grp=%0d last=%b data=%h, want 1 0 0 ff",
                  out_valid, out_group, out_last, out_data);
      end
      tick();
      total++;
      if ({out_valid, out_group, out_last, out_data} !== {1'b1, 3'd7, 1'b1, 64'hFF00_0000_0000_0000}) begin
         bad++;
         $display("FAIL skip_two_second: valid=%b grp=%0d last=%b data=%h, want 1 7 1 ff00000000000000",
                  out_valid, out_group, out_last, out_data);
      end
      tick();
      exp_cnt++;
      // All-zero vector: accepted, no beats, counted.
      in_valid  = 1'b1;
      in_spikes = '0;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL skip_zero_ready: in_ready=%b, want 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      exp_cnt++;
      #1;
      total++;
      if ({out_valid, in_ready, vec_cnt} !== {1'b0, 1'b1, exp_cnt[15:0]}) begin
         bad++;
         $display("FAIL skip_zero: valid=%b ready=%b cnt=%0d, want 0 1 %0d", out_valid, in_ready, vec_cnt, exp_cnt);
      end
      out_ready = 1'b0;
   endtask

   // G=1 instance: one beat per vector, streamed until the counter wraps.
   task automatic test_wrap();
      w_in_spikes = 8'hA5;
      w_in_valid  = 1'b1;
      w_out_ready = 1'b1;
      tick();
      for (int k = 1; k <= 65535; k++) begin
         tick();
         if (k <= 2 || k == 65535) begin
            #1;
            total++;
            if ({w_out_valid, w_out_group, w_out_last, w_in_ready, w_out_data, w_vec_cnt} !==
                {1'b1, 1'b0, 1'b1, 1'b1, 16'hCC33, k[15:0]}) begin
               bad++;
               $display("FAIL wrap_k%0d: valid=%b grp=%0d last=%b ready=%b data=%h cnt=%0d, want 1 0 1 1 cc33 %0d",
                        k, w_out_valid, w_out_group, w_out_last, w_in_ready, w_out_data, w_vec_cnt, k);
            end
         end
      end
      w_in_valid = 1'b0;
      tick();
      total++;
      if ({w_out_valid, w_vec_cnt} !== {1'b0, 16'd0}) begin
         bad++;
         $display("FAIL wrap_zero: valid=%b cnt=%0d, want 0 0", w_out_valid, w_vec_cnt);
      end
      w_out_ready = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_spikes   = '0;
      out_ready   = 1'b0;
      w_in_valid  = 1'b0;
      w_in_spikes = '0;
      w_out_ready = 1'b0;
      #1;
      test_reset();
`ifdef SPIKE_EXPAND_SKIP_ZERO_GROUP_EN
      test_skip();
`else
      test_mapping();
      test_zero_groups();
      test_backpressure();
      test_back_to_back();
`endif
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
